// File: rtl/seq_mul_pkg.sv
// ============================================================================
// Module   : seq_mul_pkg
// Brief    : Shared state encoding and mode constants for the sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mul_abs.sv
// ============================================================================
// Module   : mul_abs
// Brief    : Operand magnitude/sign split; the magnitude of the most negative
//            value still fits in WIDTH unsigned bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_abs
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] value,
  input  logic             sel,
  output logic [WIDTH-1:0] mag,
  output logic             sgn
);

  assign sgn = (sel == MODE_SIGNED) & value[WIDTH-1];
  assign mag = sgn ? (~value + WIDTH'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/seq_mul.sv
// ============================================================================
// Module   : seq_mul
// Brief    : Multi-cycle shift-add multiplier, signed/unsigned per operation,
//            full 2*WIDTH-bit product with a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sel,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_mag_a;
  logic [WIDTH-1:0]    r_mag_b;
  logic                r_neg;
  logic [2*WIDTH-1:0]  r_acc;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_out;
  logic                r_done;

  logic [WIDTH-1:0]    w_mag_a;
  logic [WIDTH-1:0]    w_mag_b;
  logic                w_sgn_a;
  logic                w_sgn_b;
  logic [2*WIDTH-1:0]  w_addend;

  mul_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value (a),
    .sel   (sel),
    .mag   (w_mag_a),
    .sgn   (w_sgn_a)
  );

  mul_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value (b),
    .sel   (sel),
    .mag   (w_mag_b),
    .sgn   (w_sgn_b)
  );

  assign w_addend = {{WIDTH{1'b0}}, r_mag_a} << r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == c_last) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= w_sgn_a ^ w_sgn_b;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          if (r_mag_b[0]) r_acc <= r_acc + w_addend;
          r_mag_b <= r_mag_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
        end
        FIN: begin
          // Negating zero yields zero, so no special case is needed.
          r_out  <= r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign out  = r_out;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul.sv
// ============================================================================
// Module   : tb_seq_mul
// Brief    : Self-checking bench for seq_mul (WIDTH=6), directed plus random.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul;

  localparam int W = 6;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            sel;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  out;

  int total = 0;
  int bad   = 0;

  seq_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: ordinary integer multiplication of the interpreted operands.
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int ix;
    int iy;
    ix = s ? int'($signed(x)) : int'(x);
    iy = s ? int'($signed(y)) : int'(y);
    return (2*W)'(ix * iy);
  endfunction

  // Called #1 after a rising edge with the DUT idle (or in its done cycle).
  // Optionally pokes a second start while busy, which must be ignored.
  task automatic op(input string tag, input logic s, input logic [W-1:0] x,
                    input logic [W-1:0] y, input logic [2*W-1:0] exp, input bit poke);
    sel = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
    for (int k = 1; k <= W + 1; k++) begin
      if (poke && k == 3) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy"}, {11'b0, busy}, {11'b0, (k <= W)});
      chk({tag, "_done"}, {11'b0, done}, {11'b0, (k == W + 1)});
    end
    chk({tag, "_out"}, out, exp);
  endtask

  initial begin
    logic            rs;
    logic [W-1:0]    ra;
    logic [W-1:0]    rb;
    logic [2*W-1:0]  held;

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", {11'b0, busy}, '0);
    chk("rst_done", {11'b0, done}, '0);
    chk("rst_out", out, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    op("sgn_mixed", 1'b1, 6'b111101, 6'b000101, 12'hFF1, 1'b0);
    @(posedge clk); #1;
    chk("done_width", {11'b0, done}, '0);
    op("uns_same", 1'b0, 6'b111101, 6'b000101, 12'h131, 1'b0);
    op("sgn_min_min", 1'b1, 6'b100000, 6'b100000, 12'h400, 1'b0);
    op("sgn_min_max", 1'b1, 6'b100000, 6'b011111, 12'hC20, 1'b0);
    op("uns_max", 1'b0, 6'b111111, 6'b111111, 12'hF81, 1'b0);
    op("zero_neg", 1'b1, 6'b000000, 6'b111001, 12'h000, 1'b0);
    op("b2b", 1'b1, 6'd2, 6'd3, 12'h006, 1'b0);

    @(posedge clk); #1;
    op("busy_poke", 1'b1, 6'd7, 6'b111110, 12'hFF2, 1'b1);
    held = out;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk); #1;
      chk("poke_nodone", {11'b0, done}, '0);
      chk("poke_hold", out, held);
    end

    // Abort mid-operation with an asynchronous reset at E3.
    sel = 1'b0; a = 6'd9; b = 6'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {11'b0, busy}, '0);
    chk("abort_done", {11'b0, done}, '0);
    chk("abort_out", out, '0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk); #1;
      chk("abort_nodone", {11'b0, done}, '0);
    end
    op("after_abort", 1'b1, 6'b111011, 6'd6, 12'hFE2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom); ra = W'($urandom); rb = W'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      op("rand", rs, ra, rb, model(rs, ra, rb), 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
